// File: rtl/rf_wb_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_pkg
// Shared definitions for the register-file writeback controller.
//   ADDR_W / DATA_W : register address and data widths (32 x 32 register file)
//   NUM_REGS        : number of architectural registers (width of pend_mask)
//   REG_ZERO        : hard-wired zero register; writes to it are dropped
//   rf_wb_entry_t   : one queued writeback {addr, data}
//   reg_onehot()    : one-hot decode of a register address
// ---------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo
// In-order queue of writeback entries. One push and one pop per cycle, both
// allowed together. The caller guarantees push only when not full and pop
// only when not empty; no internal over/underflow protection.
// All entries are exposed in age order (index 0 = head = oldest) so the
// parent can build the pending mask and forwarding without pointer math.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset (empties the queue)
//   push, push_entry enqueue one entry at the rising edge
//   pop             dequeue the head at the rising edge
//   head            current head entry (valid when count != 0)
//   count           entries currently held (0..DEPTH)
//   age_entry[i]    i-th oldest entry
//   age_valid[i]    1 when age_entry[i] holds a live entry
// ---------------------------------------------------------------------------
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  rf_wb_entry_t               push_entry,
    input  logic                       pop,
    output rf_wb_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output rf_wb_entry_t               age_entry [DEPTH],
    output logic [DEPTH-1:0]           age_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rf_wb_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage needs no reset: nothing is read unless count says it is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entry[i] = mem[rd_ptr + PTR_W'(i)];
            age_valid[i] = (CNT_W'(i) < count);
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
// Write-side controller for the 32x32 register file. Two producers (ALU and
// load unit) post writebacks; they are queued in order and drained one per
// cycle onto the register file's single write port.
//
// Handshake: a transfer happens at a rising edge where valid && ready. Ready
// depends only on queue occupancy (and, for the load unit, on alu_valid since
// the ALU has fixed priority); it never depends on a same-cycle drain, so a
// full queue refuses requests even while it is popping. Only one enqueue per
// cycle. Requests to register 0 complete the handshake but are discarded.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   alu_valid/ready/addr/data   ALU writeback request (priority)
//   mem_valid/ready/addr/data   load-unit writeback request
//   rf_hold                1 = leave the queue head in place this cycle
//   rf_writeEn/addr/data_in     registered register-file write port
//   pend_mask              registers with a queued or in-flight write
//   q_count                entries currently queued
//   rd_addr1/2             read addresses presented to the register file
//   fwd_hit1/2, fwd_data1/2     youngest queued/in-flight write to rd_addrN
//
// Build option: define RF_WB_FWD_EN to enable the forwarding compare logic;
// otherwise fwd_hitN/fwd_dataN are tied to zero.
// ---------------------------------------------------------------------------
module regfile_wb_ctrl
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   rf_hold,
    output logic                   rf_writeEn,
    output logic [ADDR_W-1:0]      rf_addr,
    output logic [DATA_W-1:0]      rf_data_in,
    output logic [NUM_REGS-1:0]    pend_mask,
    output logic [$clog2(DEPTH):0] q_count,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic                   fwd_hit1,
    output logic [DATA_W-1:0]      fwd_data1,
    output logic                   fwd_hit2,
    output logic [DATA_W-1:0]      fwd_data2
);

    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic         not_full;
    logic         alu_fire;
    logic         mem_fire;
    logic         push;
    logic         pop;
    rf_wb_entry_t push_entry;
    rf_wb_entry_t head;
    rf_wb_entry_t age_entry [DEPTH];
    logic [DEPTH-1:0] age_valid;

    // ---------------- arbitration ----------------
    assign not_full  = (q_count < FULL_CNT);
    assign alu_ready = not_full;
    assign mem_ready = !alu_valid && not_full;

    assign alu_fire = alu_valid && alu_ready;
    assign mem_fire = mem_valid && mem_ready;

    always_comb begin
        push_entry = '0;
        push       = 1'b0;
        if (alu_fire) begin
            push_entry.addr = alu_addr;
            push_entry.data = alu_data;
            push            = (alu_addr != REG_ZERO);
        end else if (mem_fire) begin
            push_entry.addr = mem_addr;
            push_entry.data = mem_data;
            push            = (mem_addr != REG_ZERO);
        end
    end

    assign pop = !rf_hold && (q_count != '0);

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (q_count),
        .age_entry  (age_entry),
        .age_valid  (age_valid)
    );

    // ---------------- write port register ----------------
    // Address/data keep their last value when idle; only writeEn drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_writeEn <= 1'b0;
            rf_addr    <= '0;
            rf_data_in <= '0;
        end else if (pop) begin
            rf_writeEn <= 1'b1;
            rf_addr    <= head.addr;
            rf_data_in <= head.data;
        end else begin
            rf_writeEn <= 1'b0;
        end
    end

    // ---------------- pending mask ----------------
    // The in-flight write still counts as pending until the register file
    // has captured it at the end of the rf_writeEn cycle.
    always_comb begin
        pend_mask = '0;
        if (rf_writeEn) begin
            pend_mask = pend_mask | reg_onehot(rf_addr);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (age_valid[i]) begin
                pend_mask = pend_mask | reg_onehot(age_entry[i].addr);
            end
        end
    end

    // ---------------- forwarding ----------------
`ifdef RF_WB_FWD_EN
    // Scan oldest to youngest (in-flight first, then queue head onward) so
    // the last match is the youngest write to that register.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] a);
        logic              hit;
        logic [DATA_W-1:0] d;
        hit = 1'b0;
        d   = '0;
        if (a != REG_ZERO) begin
            if (rf_writeEn && (rf_addr == a)) begin
                hit = 1'b1;
                d   = rf_data_in;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (age_valid[i] && (age_entry[i].addr == a)) begin
                    hit = 1'b1;
                    d   = age_entry[i].data;
                end
            end
        end
        return {hit, d};
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = fwd_lookup(rd_addr1);
        {fwd_hit2, fwd_data2} = fwd_lookup(rd_addr2);
    end
`else
    logic unused_fwd;

    assign fwd_hit1  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data2 = '0;

    // Read addresses and queued data only matter when forwarding is built.
    always_comb begin
        unused_fwd = ^{rd_addr1, rd_addr2};
        for (int i = 0; i < DEPTH; i++) begin
            unused_fwd = unused_fwd ^ (^age_entry[i].data);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
// Directed bench for regfile_wb_ctrl. Inputs change 2 time units after a
// rising edge; direct checks sample in the same window, and the write-port
// scoreboard samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;
    import rf_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                clk;
    logic                rst;
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                rf_hold;
    logic                rf_writeEn;
    logic [ADDR_W-1:0]   rf_addr;
    logic [DATA_W-1:0]   rf_data_in;
    logic [NUM_REGS-1:0] pend_mask;
    logic [CNT_W-1:0]    q_count;
    logic [ADDR_W-1:0]   rd_addr1;
    logic [ADDR_W-1:0]   rd_addr2;
    logic                fwd_hit1;
    logic [DATA_W-1:0]   fwd_data1;
    logic                fwd_hit2;
    logic [DATA_W-1:0]   fwd_data2;

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .rf_hold    (rf_hold),
        .rf_writeEn (rf_writeEn),
        .rf_addr    (rf_addr),
        .rf_data_in (rf_data_in),
        .pend_mask  (pend_mask),
        .q_count    (q_count),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_data1  (fwd_data1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data2  (fwd_data2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write-port cycle must match the next expected write.
    always @(negedge clk) begin
        if (rst && rf_writeEn) begin
            if (exp_q.size() == 0) begin
                check_val("wr_unexpected", {31'd0, rf_writeEn}, 64'd0);
            end else begin
                check_val("wr_entry", {27'd0, rf_addr, rf_data_in}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic drive_mem(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_data  = d;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        rf_hold = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b0, '0, '0);
        step();
        step();

        // Reset state
        check_val("rst_q_count",   64'(q_count),    64'd0);
        check_val("rst_pend_mask", 64'(pend_mask),  64'd0);
        check_val("rst_writeEn",   64'(rf_writeEn), 64'd0);
        check_val("rst_rf_addr",   64'(rf_addr),    64'd0);
        check_val("rst_rf_data",   64'(rf_data_in), 64'd0);
        check_val("rst_fwd_hit1",  64'(fwd_hit1),   64'd0);
        rst = 1'b1;
        step();

        // 1: single ALU write r5 = DEADBEEF
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        expect_write(5'd5, 32'hDEADBEEF);
        #1;
        check_val("t1_alu_ready", 64'(alu_ready), 64'd1);
        step();                                   // cycle 1
        drive_alu(1'b0, '0, '0);
        check_val("t1_c1_q_count", 64'(q_count),    64'd1);
        check_val("t1_c1_pend",    64'(pend_mask),  64'h20);
        check_val("t1_c1_wen",     64'(rf_writeEn), 64'd0);
        step();                                   // cycle 2
        check_val("t1_c2_wen",     64'(rf_writeEn), 64'd1);
        check_val("t1_c2_addr",    64'(rf_addr),    64'd5);
        check_val("t1_c2_data",    64'(rf_data_in), 64'hDEADBEEF);
        check_val("t1_c2_pend",    64'(pend_mask),  64'h20);
        step();                                   // cycle 3
        check_val("t1_c3_pend",    64'(pend_mask),  64'd0);
        check_val("t1_c3_wen",     64'(rf_writeEn), 64'd0);
        check_val("t1_c3_addr_hold", 64'(rf_addr),  64'd5);

        // 2: simultaneous ALU and load requests
        drive_alu(1'b1, 5'd1, 32'h11);
        drive_mem(1'b1, 5'd2, 32'h22);
        expect_write(5'd1, 32'h11);
        expect_write(5'd2, 32'h22);
        #1;
        check_val("t2_alu_ready", 64'(alu_ready), 64'd1);
        check_val("t2_mem_ready", 64'(mem_ready), 64'd0);
        step();
        drive_alu(1'b0, '0, '0);
        #1;
        check_val("t2_mem_ready_after", 64'(mem_ready), 64'd1);
        step();
        drive_mem(1'b0, '0, '0);
        check_val("t2_first_addr",  64'(rf_addr), 64'd1);
        step();
        check_val("t2_second_wen",  64'(rf_writeEn), 64'd1);
        check_val("t2_second_addr", 64'(rf_addr),    64'd2);
        step();
        check_val("t2_idle_wen",    64'(rf_writeEn), 64'd0);

        // 3: fill under hold, fifth request refused, then drain in order
        rf_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_alu(1'b1, 5'(10 + i), 32'(32'h100 + i));
            #1;
            check_val($sformatf("t3_ready_%0d", i), 64'(alu_ready), (i < 4) ? 64'd1 : 64'd0);
            step();
        end
        drive_alu(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) expect_write(5'(10 + i), 32'(32'h100 + i));
        check_val("t3_q_full",    64'(q_count),   64'd4);
        check_val("t3_pend",      64'(pend_mask), 64'h3C00);
        check_val("t3_mem_ready", 64'(mem_ready), 64'd0);
        rf_hold = 1'b0;
        #1;
        check_val("t3_no_passthru", 64'(alu_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("t3_drain_wen_%0d", i),  64'(rf_writeEn), 64'd1);
            check_val($sformatf("t3_drain_addr_%0d", i), 64'(rf_addr),    64'(10 + i));
        end
        step();
        check_val("t3_end_wen",   64'(rf_writeEn), 64'd0);
        check_val("t3_end_count", 64'(q_count),    64'd0);

        // 4: write to r0 is accepted and dropped
        drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check_val("t4_ready", 64'(alu_ready), 64'd1);
        step();
        drive_alu(1'b0, '0, '0);
        check_val("t4_q_count", 64'(q_count),   64'd0);
        check_val("t4_pend",    64'(pend_mask), 64'd0);
        step();
        check_val("t4_wen", 64'(rf_writeEn), 64'd0);
        step();

        // 5: two writes to r7 queued under hold; forward youngest
        rf_hold = 1'b1;
        drive_alu(1'b1, 5'd7, 32'h1);
        step();
        drive_alu(1'b1, 5'd7, 32'h2);
        step();
        drive_alu(1'b0, '0, '0);
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd0;
        #1;
        check_val("t5_q_count", 64'(q_count),   64'd2);
        check_val("t5_pend",    64'(pend_mask), 64'h80);
`ifdef RF_WB_FWD_EN
        check_val("t5_fwd_hit1",  64'(fwd_hit1),  64'd1);
        check_val("t5_fwd_data1", 64'(fwd_data1), 64'h2);
`else
        check_val("t5_fwd_hit1",  64'(fwd_hit1),  64'd0);
        check_val("t5_fwd_data1", 64'(fwd_data1), 64'd0);
`endif
        check_val("t5_fwd_hit2_r0", 64'(fwd_hit2), 64'd0);
        expect_write(5'd7, 32'h1);
        expect_write(5'd7, 32'h2);
        rf_hold = 1'b0;
        step();
        step();
        check_val("t5_second_data", 64'(rf_data_in), 64'h2);
        step();
        rd_addr1 = '0;

        // 6: asynchronous reset with three entries queued
        rf_hold = 1'b1;
        drive_alu(1'b1, 5'd3, 32'h33);
        step();
        drive_alu(1'b1, 5'd4, 32'h44);
        step();
        drive_alu(1'b1, 5'd6, 32'h66);
        step();
        drive_alu(1'b0, '0, '0);
        check_val("t6_q_count_pre", 64'(q_count), 64'd3);
        #1;
        rst = 1'b0;
        #1;
        check_val("t6_q_count", 64'(q_count),    64'd0);
        check_val("t6_pend",    64'(pend_mask),  64'd0);
        check_val("t6_wen",     64'(rf_writeEn), 64'd0);
        check_val("t6_addr",    64'(rf_addr),    64'd0);
        check_val("t6_data",    64'(rf_data_in), 64'd0);
        step();
        rst = 1'b1;
        rf_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("t6_post_wen_%0d", i), 64'(rf_writeEn), 64'd0);
        end

        check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
